// File: rtl/frame_blitter_if.sv
// Bus bundle for frame_blitter: Avalon-MM read master toward shared memory
// and Avalon-MM write master toward the pixel buffer.
interface frame_blitter_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [7:0]  mem_readdata;

  logic [31:0] vga_address;
  logic        vga_write;
  logic        vga_waitrequest;
  logic [15:0] vga_writedata;

  modport master (
    output mem_address, mem_read,
    input  mem_waitrequest, mem_readdata,
    output vga_address, vga_write, vga_writedata,
    input  vga_waitrequest
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_waitrequest, mem_readdata,
    input  vga_address, vga_write, vga_writedata,
    output vga_waitrequest
  );
endinterface

// File: rtl/frame_blitter.sv
// Copies one indexed frame from shared memory to an RGB565 pixel buffer,
// one read + one write per pixel, palette lookup from the captured index.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; bases latched on the start cycle
//   S_READ  | mem_read asserted for pixel (x,y) until waitrequest drops
//   S_WRITE | vga_write asserted with palette colour until accepted
//   S_DONE  | frame finished; done pulses once, wait for start to drop
module frame_blitter #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0][31:0]       hps_params,
  input  logic [255:0][2:0][7:0] local_palette,
  frame_blitter_if.master        bus,
  output logic                   processing,
  output logic                   done
);

  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XW-1:0]   r_x;
  logic [XW-1:0]   w_x_nxt;
  logic [YW-1:0]   r_y;
  logic [YW-1:0]   w_y_nxt;
  logic [31:0]     r_src_base;
  logic [31:0]     w_src_base_nxt;
  logic [31:0]     r_dst_base;
  logic [31:0]     w_dst_base_nxt;
  logic [31:0]     r_pix_off;
  logic [31:0]     w_pix_off_nxt;
  logic [7:0]      r_index;
  logic [7:0]      w_index_nxt;
  logic            r_done_seen;

  logic [2:0][7:0] w_pal;
  logic [31:0]     w_dst_off;
  logic [15:0]     w_rgb565;
  logic            w_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_pix_off  <= '0;
      r_index    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_src_base <= w_src_base_nxt;
      r_dst_base <= w_dst_base_nxt;
      r_pix_off  <= w_pix_off_nxt;
      r_index    <= w_index_nxt;
    end
  end

  // Lets done mark only the first cycle spent in S_DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_seen <= 1'b0;
    end else begin
      r_done_seen <= (r_state == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_src_base_nxt = r_src_base;
    w_dst_base_nxt = r_dst_base;
    w_pix_off_nxt  = r_pix_off;
    w_index_nxt    = r_index;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_base_nxt = hps_params[2];
          w_dst_base_nxt = hps_params[3];
          w_x_nxt        = '0;
          w_y_nxt        = '0;
          w_pix_off_nxt  = '0;
          w_state_nxt    = S_READ;
        end
      end
      S_READ: begin
        if (!bus.mem_waitrequest) begin
          w_index_nxt = bus.mem_readdata;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!bus.vga_waitrequest) begin
          if (r_x != X_LAST) begin
            w_x_nxt       = r_x + XW'(1);
            w_pix_off_nxt = r_pix_off + 32'd1;
            w_state_nxt   = S_READ;
          end else if (r_y != Y_LAST) begin
            w_x_nxt       = '0;
            w_y_nxt       = r_y + YW'(1);
            w_pix_off_nxt = r_pix_off + 32'd1;
            w_state_nxt   = S_READ;
          end else begin
            w_state_nxt   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Source pixels are contiguous, so a running offset replaces y*SCREEN_W+x.
  assign w_dst_off = (32'(r_y) << 10) + (32'(r_x) << 1);
  assign w_pal     = local_palette[r_index];
  assign w_rgb565  = {w_pal[0][7:3], w_pal[1][7:2], w_pal[2][7:3]};

  assign bus.mem_read      = (r_state == S_READ);
  assign bus.mem_address   = (r_state == S_READ) ? (r_src_base + r_pix_off) : 32'd0;
  assign bus.vga_write     = (r_state == S_WRITE);
  assign bus.vga_address   = (r_state == S_WRITE) ? (r_dst_base + w_dst_off) : 32'd0;
  assign bus.vga_writedata = (r_state == S_WRITE) ? w_rgb565 : 16'd0;

  assign processing = (r_state == S_READ) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE) && !r_done_seen;

  assign w_unused = ^{hps_params[1:0], hps_params[7:4],
                      w_pal[0][2:0], w_pal[1][1:0], w_pal[2][2:0]};

endmodule

// File: doc/frame_blitter.md
FRAME_BLITTER -- requirements
Module: frame_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, source/dest frame width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 200, frame height in lines.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level request to blit one frame.
REQ-006 SHALL have port hps_params  input  8x32  [2]=source indexed-frame base byte address, [3]=pixel-buffer base byte address.
REQ-007 SHALL have port local_palette  input  256x3x8  [i][0]=R, [i][1]=G, [i][2]=B, filled by the upstream palette stage.
REQ-008 SHALL have ports mem_address (output 32), mem_read (output 1), mem_waitrequest (input 1), mem_readdata (input 8)  Avalon-MM read master to shared memory.
REQ-009 SHALL have ports vga_address (output 32), vga_write (output 1), vga_waitrequest (input 1), vga_writedata (output 16)  Avalon-MM write master to pixel buffer.
REQ-010 SHALL have port processing  output  1  high while a frame is in flight.
REQ-011 SHALL have port done  output  1  one-cycle pulse on frame completion.

Function
REQ-012 SHALL implement states IDLE, READ, WRITE, DONE, with counters x (0..SCREEN_W-1) and y (0..SCREEN_H-1).
REQ-013 IDLE: on start=1 SHALL latch hps_params[2] and hps_params[3], clear x and y, and enter READ next cycle.
REQ-014 READ: SHALL drive mem_read=1, mem_address = src_base + y*SCREEN_W + x, and hold both stable while mem_waitrequest=1.
REQ-015 READ: in the cycle with mem_waitrequest=0, SHALL capture mem_readdata as index and enter WRITE.
REQ-016 WRITE: SHALL drive vga_write=1, vga_address = dst_base + (y<<10) + (x<<1), and vga_writedata = {R[7:3], G[7:2], B[7:3]} of local_palette[index]; all held stable while vga_waitrequest=1.
REQ-017 WRITE: on vga_waitrequest=0, if x<SCREEN_W-1 SHALL increment x and enter READ.
REQ-018 WRITE: on vga_waitrequest=0 with x=SCREEN_W-1 and y<SCREEN_H-1, SHALL clear x, increment y, and enter READ.
REQ-019 WRITE: on vga_waitrequest=0 with x=SCREEN_W-1 and y=SCREEN_H-1, SHALL enter DONE.
REQ-020 DONE: SHALL pulse done=1 for exactly the first DONE cycle, remain in DONE while start=1, and return to IDLE when start=0 (no retrigger on held start).
REQ-021 processing SHALL be 1 in READ and WRITE and 0 in IDLE and DONE.
REQ-022 mem_read and vga_write SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-023 start changes and hps_params changes during READ/WRITE SHALL be ignored; latched bases are used until DONE.
REQ-024 Address arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32 without error.
REQ-025 Throughput with both waitrequests held 0 SHALL be 2 cycles/pixel: SCREEN_W*SCREEN_H*2 cycles from first READ to DONE.
REQ-026 Palette lookup SHALL be combinational from the registered index; local_palette changes mid-frame affect only subsequent writes.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, x=y=0, latched bases=0, index=0, and all outputs to 0 (addresses, data, read, write, processing, done).
REQ-028 reset asserted mid-frame SHALL abort immediately; no further bus requests until a new start after reset release.
REQ-029 After reset release SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-030 Idle/reset: reset=0 then 1, start=0 for 10 cycles -> state IDLE, mem_read=0, vga_write=0, processing=0, done=0.
REQ-031 First pixel: hps_params[2]=32'hC0000000, [3]=32'hC8000000, palette[5]={8'hFF,8'h80,8'h08}, mem_readdata=5, start=1 -> mem_address=32'hC0000000; then vga_address=32'hC8000000, vga_writedata=16'hFC01.
REQ-032 Line wrap: at x=319, y=0 -> next mem_address=32'hC0000140, vga_address=32'hC8000400.
REQ-033 Waitrequest stall: mem_waitrequest=1 for 3 cycles, then vga_waitrequest=1 for 4 cycles -> address/data/read/write held constant, exactly one capture and one write accepted.
REQ-034 Full frame, no stalls: start held 1 -> processing high for exactly 128000 cycles, exactly 64000 writes, done pulses once; FSM stays DONE until start=0, then IDLE.
REQ-035 Mid-frame reset: reset=0 at pixel 100 -> same cycle mem_read=vga_write=processing=0; after release with start=1 -> restart at mem_address=src base.
